// File: rtl/ecall_io_if.sv
`default_nettype none
// ============================================================================
//  Module   : ecall_io_if
//  Purpose  : Fetch-stall handshake between the decode/fetch side and the
//             ecall I/O responder. It also carries the register-file write-back
//             path for read-int results.
//  Revision : 1.0  initial release
// ============================================================================
interface ecall_io_if;
  logic        ecall;
  logic [31:0] a7;
  logic [31:0] a0;
  logic        continue_button;
  logic        pc_change;
  logic [2:0]  test_number;
  logic [31:0] rd_wdata;
  logic        rd_we;

  // Core side: presents the decoded ecall and waits for release
  modport master (
    output ecall, a7, a0,
    input  continue_button, pc_change, test_number, rd_wdata, rd_we
  );

  // Responder side: services the ecall against board I/O
  modport slave (
    input  ecall, a7, a0,
    output continue_button, pc_change, test_number, rd_wdata, rd_we
  );
endinterface
`default_nettype wire

// File: rtl/ecall_io_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : ecall_io_ctrl
//  Purpose  : Services ecalls against LEDs, switches and push-buttons. It
//             returns a one-cycle continue pulse to fetch and raises a
//             test-restart pulse (pc_change and test_number) from the test button.
//  Revision : 1.0  initial release
// ============================================================================
module ecall_io_ctrl #(
  parameter int DB_LIMIT = 500000,
  parameter int DB_W     = 20
) (
  input  wire logic        clock,
  input  wire logic        reset,
  ecall_io_if.slave        io,
  input  wire logic        cont_btn_raw,
  input  wire logic        test_btn_raw,
  input  wire logic [15:0] switches,
  output logic      [15:0] led,
  output logic             busy,
  output logic             halted
);

  localparam logic [DB_W-1:0] c_db_last   = DB_W'(DB_LIMIT - 1);
  localparam logic [31:0]     c_svc_print = 32'd1;
  localparam logic [31:0]     c_svc_read  = 32'd5;
  localparam logic [31:0]     c_svc_exit  = 32'd10;

  // Index 0 is the continue button and index 1 is the test button
  logic [1:0] w_btn_raw;
  logic [1:0] w_btn_edge;
  logic [1:0] w_btn_rise_next;

  assign w_btn_raw = {test_btn_raw, cont_btn_raw};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_btn
      logic            r_sync1;
      logic            r_sync2;
      logic            r_stable;
      logic            r_stable_d;
      logic [DB_W-1:0] r_cnt;

      // Synchronise the raw button. Accept a new level only after it stays different for DB_LIMIT cycles.
      always_ff @(posedge clock) begin
        if (reset) begin
          r_sync1    <= 1'b0;
          r_sync2    <= 1'b0;
          r_stable   <= 1'b0;
          r_stable_d <= 1'b0;
          r_cnt      <= '0;
        end else begin
          r_sync1    <= w_btn_raw[gi];
          r_sync2    <= r_sync1;
          r_stable_d <= r_stable;
          if (r_sync2 == r_stable) begin
            r_cnt <= '0;
          end else if (r_cnt == c_db_last) begin
            r_stable <= r_sync2;
            r_cnt    <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
      end

      assign w_btn_edge[gi]      = r_stable & ~r_stable_d;
      // True in the cycle before the stable level rises. It lets registered
      // outputs land in the same cycle as the edge.
      assign w_btn_rise_next[gi] = r_sync2 & ~r_stable & (r_cnt == c_db_last);
    end
  endgenerate

  logic [15:0] r_sw_sync1;
  logic [15:0] r_sw_sync2;

  // Switches are slow levels and only need the metastability guard
  always_ff @(posedge clock) begin
    if (reset) begin
      r_sw_sync1 <= '0;
      r_sw_sync2 <= '0;
    end else begin
      r_sw_sync1 <= switches;
      r_sw_sync2 <= r_sw_sync1;
    end
  end

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WAIT = 3'd1,
    S_DONE = 3'd2,
    S_HALT = 3'd3
  } state_t;

  state_t      r_state;
  logic        r_is_read;
  logic        r_continue;
  logic        r_pc_change;
  logic [2:0]  r_test_number;
  logic [15:0] r_led;
  logic [31:0] r_rd_wdata;
  logic        r_rd_we;
  logic        r_busy;
  logic        r_halted;

  // Service FSM. A test restart overrides everything, including HALT. All outputs are registered.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_is_read     <= 1'b0;
      r_continue    <= 1'b0;
      r_pc_change   <= 1'b0;
      r_test_number <= '0;
      r_led         <= '0;
      r_rd_wdata    <= '0;
      r_rd_we       <= 1'b0;
      r_busy        <= 1'b0;
      r_halted      <= 1'b0;
    end else begin
      r_continue  <= 1'b0;
      r_rd_we     <= 1'b0;
      r_pc_change <= w_btn_rise_next[1];
      if (w_btn_rise_next[1]) begin
        r_test_number <= r_sw_sync2[2:0];
      end

      if (w_btn_edge[1]) begin
        r_state   <= S_IDLE;
        r_is_read <= 1'b0;
        r_busy    <= 1'b0;
        r_halted  <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (io.ecall) begin
              r_is_read <= (io.a7 == c_svc_read);
              if (io.a7 == c_svc_print) begin
                r_led   <= io.a0[15:0];
                r_busy  <= 1'b1;
                r_state <= S_WAIT;
              end else if (io.a7 == c_svc_read) begin
                r_busy  <= 1'b1;
                r_state <= S_WAIT;
              end else if (io.a7 == c_svc_exit) begin
                r_halted <= 1'b1;
                r_state  <= S_HALT;
              end else begin
                r_continue <= 1'b1;
                r_state    <= S_DONE;
              end
            end
          end
          S_WAIT: begin
            if (w_btn_edge[0]) begin
              r_busy     <= 1'b0;
              r_continue <= 1'b1;
              r_rd_we    <= r_is_read;
              r_state    <= S_DONE;
              if (r_is_read) begin
                r_rd_wdata <= {{16{r_sw_sync2[15]}}, r_sw_sync2};
              end
            end
          end
          S_DONE:  r_state <= S_IDLE;
          S_HALT:  r_state <= S_HALT;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign io.continue_button = r_continue;
  assign io.pc_change       = r_pc_change;
  assign io.test_number     = r_test_number;
  assign io.rd_wdata        = r_rd_wdata;
  assign io.rd_we           = r_rd_we;
  assign led                = r_led;
  assign busy               = r_busy;
  assign halted             = r_halted;

  // Only the low half of a0 reaches the LEDs. The continue button needs no look-ahead.
  logic w_unused;
  assign w_unused = ^{io.a0[31:16], w_btn_rise_next[0]};

endmodule
`default_nettype wire

// File: tb/tb_ecall_io_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ecall_io_ctrl
//  Purpose  : Self-checking bench for ecall_io_ctrl. It uses a table of
//             service vectors and a scoreboard of expected write-back values,
//             plus hand-written halt, glitch, abort and reset sequences.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ecall_io_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        cont_btn_raw;
  logic        test_btn_raw;
  logic [15:0] switches;
  logic [15:0] led;
  logic        busy;
  logic        halted;

  ecall_io_if bus ();

  ecall_io_ctrl #(.DB_LIMIT(4), .DB_W(4)) dut (
    .clock        (clock),
    .reset        (reset),
    .io           (bus.slave),
    .cont_btn_raw (cont_btn_raw),
    .test_btn_raw (test_btn_raw),
    .switches     (switches),
    .led          (led),
    .busy         (busy),
    .halted       (halted)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        rd_we;
    logic [31:0] rd_wdata;
    logic [15:0] led;
  } exp_t;

  typedef struct {
    logic [31:0] a7;
    logic [31:0] a0;
    logic [15:0] sw;
    logic        press;
    logic        exp_busy;
    logic [15:0] exp_led;
    logic [31:0] exp_rdata;
    logic        exp_we;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[6];

  int checks   = 0;
  int failures = 0;
  int n_cont   = 0;
  int n_pc     = 0;
  int n_stray  = 0;
  logic [2:0] seen_tn;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
    end
  endtask

  // One clock. Models fetch: it drops ecall on a continue or restart and scores write-backs.
  task automatic step();
    exp_t e;
    @(posedge clock);
    #1;
    if (bus.pc_change) begin
      n_pc++;
      bus.ecall = 1'b0;
    end
    if (bus.rd_we && !bus.continue_button) n_stray++;
    if (bus.continue_button) begin
      n_cont++;
      bus.ecall = 1'b0;
      if (sb.size() == 0) begin
        check("unexpected_continue", {31'd0, bus.continue_button}, 32'd0);
      end else begin
        e = sb.pop_front();
        check("rd_we", {31'd0, bus.rd_we}, {31'd0, e.rd_we});
        check("rd_wdata", bus.rd_wdata, e.rd_wdata);
        check("led_at_continue", {16'd0, led}, {16'd0, e.led});
      end
    end
  endtask

  initial begin
    bus.ecall    = 1'b0;
    bus.a7       = '0;
    bus.a0       = '0;
    cont_btn_raw = 1'b0;
    test_btn_raw = 1'b0;
    switches     = '0;
    reset        = 1'b1;

    //          a7      a0             sw        press busy  led       rdata          we
    vecs[0] = '{32'd1,  32'h0001_ABCD, 16'h0000, 1'b1, 1'b1, 16'hABCD, 32'h0000_0000, 1'b0};
    vecs[1] = '{32'd5,  32'h0000_0000, 16'h8003, 1'b1, 1'b1, 16'hABCD, 32'hFFFF_8003, 1'b1};
    vecs[2] = '{32'd7,  32'h0000_1111, 16'h0000, 1'b0, 1'b0, 16'hABCD, 32'hFFFF_8003, 1'b0};
    vecs[3] = '{32'd1,  32'h1234_0042, 16'h0000, 1'b1, 1'b1, 16'h0042, 32'hFFFF_8003, 1'b0};
    vecs[4] = '{32'd5,  32'h0000_0000, 16'h7FFF, 1'b1, 1'b1, 16'h0042, 32'h0000_7FFF, 1'b1};
    vecs[5] = '{32'd0,  32'h0000_2222, 16'h0000, 1'b0, 1'b0, 16'h0042, 32'h0000_7FFF, 1'b0};

    // T1: reset held with the continue button pressed
    cont_btn_raw = 1'b1;
    repeat (3) step();
    check("rst_continue", {31'd0, bus.continue_button}, 32'd0);
    check("rst_pc_change", {31'd0, bus.pc_change}, 32'd0);
    check("rst_test_number", {29'd0, bus.test_number}, 32'd0);
    check("rst_led", {16'd0, led}, 32'd0);
    check("rst_rd_wdata", bus.rd_wdata, 32'd0);
    check("rst_rd_we", {31'd0, bus.rd_we}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_halted", {31'd0, halted}, 32'd0);
    reset = 1'b0;
    repeat (12) step();
    check("idle_ignores_cont", n_cont, 32'd0);
    cont_btn_raw = 1'b0;
    repeat (8) step();

    // Table of services
    for (int i = 0; i < 6; i++) begin
      n_cont  = 0;
      n_stray = 0;
      bus.a7   = vecs[i].a7;
      bus.a0   = vecs[i].a0;
      switches = vecs[i].sw;
      bus.ecall = 1'b1;
      sb.push_back('{vecs[i].exp_we, vecs[i].exp_rdata, vecs[i].exp_led});
      step();
      // a7/a0 are latched at dispatch. Later changes must not matter.
      bus.a7 = 32'd0;
      bus.a0 = 32'hDEAD_BEEF;
      check("busy_after_dispatch", {31'd0, busy}, {31'd0, vecs[i].exp_busy});
      check("led_after_dispatch", {16'd0, led}, {16'd0, vecs[i].exp_led});
      if (vecs[i].press) begin
        check("no_early_continue", n_cont, 32'd0);
        cont_btn_raw = 1'b1;
        repeat (8) step();
        cont_btn_raw = 1'b0;
        repeat (8) step();
      end else begin
        // The ecall is seen in cycle 1 (IDLE) and continue fires in cycle 2 (DONE)
        check("noop_latency", n_cont, 32'd1);
        repeat (3) step();
      end
      check("single_continue", n_cont, 32'd1);
      check("scoreboard_drained", sb.size(), 32'd0);
      check("rd_we_outside_done", n_stray, 32'd0);
      check("busy_after_service", {31'd0, busy}, 32'd0);
    end

    // T5: exit halts. Continue is ignored and a test press restarts.
    n_cont = 0;
    n_pc   = 0;
    bus.a7 = 32'd10;
    bus.a0 = 32'd0;
    bus.ecall = 1'b1;
    step();
    check("halted_set", {31'd0, halted}, 32'd1);
    check("halt_not_busy", {31'd0, busy}, 32'd0);
    cont_btn_raw = 1'b1;
    repeat (8) step();
    cont_btn_raw = 1'b0;
    repeat (8) step();
    check("halt_ignores_cont", n_cont, 32'd0);
    check("still_halted", {31'd0, halted}, 32'd1);
    switches = 16'h0005;
    test_btn_raw = 1'b1;
    seen_tn = 3'd0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (bus.pc_change) seen_tn = bus.test_number;
    end
    test_btn_raw = 1'b0;
    repeat (8) step();
    check("halt_restart_pulses", n_pc, 32'd1);
    check("test_number_at_pulse", {29'd0, seen_tn}, 32'd5);
    check("test_number_holds", {29'd0, bus.test_number}, 32'd5);
    check("halted_cleared", {31'd0, halted}, 32'd0);
    check("led_kept_on_restart", {16'd0, led}, 32'h0000_0042);
    check("restart_no_continue", n_cont, 32'd0);

    // T6: a glitch in WAIT gives no edge. Then test and cont are pressed together.
    n_cont = 0;
    n_pc   = 0;
    bus.a7 = 32'd1;
    bus.a0 = 32'h0000_5555;
    bus.ecall = 1'b1;
    step();
    check("wait_busy", {31'd0, busy}, 32'd1);
    check("wait_led", {16'd0, led}, 32'h0000_5555);
    cont_btn_raw = 1'b1;
    repeat (2) step();
    cont_btn_raw = 1'b0;
    repeat (10) step();
    check("glitch_no_continue", n_cont, 32'd0);
    check("glitch_still_busy", {31'd0, busy}, 32'd1);
    switches = 16'h0002;
    repeat (3) step();
    cont_btn_raw = 1'b1;
    test_btn_raw = 1'b1;
    repeat (10) step();
    cont_btn_raw = 1'b0;
    test_btn_raw = 1'b0;
    repeat (8) step();
    check("both_pc_change", n_pc, 32'd1);
    check("both_no_continue", n_cont, 32'd0);
    check("both_test_number", {29'd0, bus.test_number}, 32'd2);
    check("both_back_idle", {31'd0, busy}, 32'd0);

    // Reset in the middle of WAIT: back to IDLE with no pulses
    n_cont  = 0;
    n_stray = 0;
    bus.a7 = 32'd5;
    bus.ecall = 1'b1;
    step();
    check("pre_reset_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    bus.ecall = 1'b0;
    step();
    check("midwait_reset_busy", {31'd0, busy}, 32'd0);
    check("midwait_reset_rd_wdata", bus.rd_wdata, 32'd0);
    check("midwait_reset_led", {16'd0, led}, 32'd0);
    cont_btn_raw = 1'b1;
    repeat (8) step();
    cont_btn_raw = 1'b0;
    repeat (8) step();
    check("midwait_reset_no_continue", n_cont, 32'd0);
    check("midwait_reset_no_rd_we", n_stray, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
